// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: multi-cycle shift-add multiplier, BITS_PER_CYCLE rows per clock, unsigned or signed
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);
  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [W2-1:0] a_sh, acc, acc_d, row, p_r;
  logic [WIDTH-1:0] b_sh;
  logic sm;
  logic [CW-1:0] cnt;
  logic accept, last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign P         = p_r;
  assign accept    = in_valid & in_ready;
  assign last      = state == RUN && cnt == '0;
  always_comb begin
    state_d = state;
    if (accept) state_d = RUN;
    else if (last) state_d = DONE;
    else if (state == DONE && out_ready) state_d = IDLE;
  end
  // the final row of the final cycle is B's MSB; in signed mode it carries negative weight
  always_comb begin
    acc_d = acc;
    row = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      row = b_sh[j] ? a_sh << j : '0;
      acc_d = (sm && cnt == '0 && j == BITS_PER_CYCLE - 1) ? acc_d - row : acc_d + row;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      p_r   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      sm    <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_sh <= signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_sh <= B;
        sm   <= signed_mode;
        acc  <= '0;
        cnt  <= CW'(N - 1);
      end else if (state == RUN) begin
        acc  <= acc_d;
        a_sh <= a_sh << BITS_PER_CYCLE;
        b_sh <= b_sh >> BITS_PER_CYCLE;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) p_r <= acc_d;
      end
    end
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed vectors on an 8-bit instance plus exhaustive 4-bit runs for BPC 1, 2, 4
module tb_seq_shift_add_multiplier;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, sm = 0;
  logic [7:0] A = 0, B = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] P;
  logic iv4 = 0, sm4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic ir4 [3], ov4 [3], bz4 [3];
  logic [7:0] p4 [3];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .signed_mode(sm), .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy));

  for (genvar k = 0; k < 3; k++) begin : g4
    seq_shift_add_multiplier #(.WIDTH(4), .BITS_PER_CYCLE(1 << k)) u (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4[k]), .A(a4), .B(b4),
      .signed_mode(sm4), .out_valid(ov4[k]), .out_ready(1'b1), .P(p4[k]), .busy(bz4[k]));
  end

  typedef struct {logic [7:0] a; logic [7:0] b; logic s; logic [15:0] p;} vec_t;
  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic xact8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp, input string nm);
    int lat;
    chk({nm, " in_ready"}, in_ready, 1);
    A = a; B = b; sm = s; in_valid = 1;
    step();
    in_valid = 0;
    A = ~a; B = ~b; sm = ~s;
    wait_ov(lat);
    chk({nm, " latency"}, lat, 8);
    chk({nm, " P"}, P, exp);
    out_ready = 1;
    step();
    out_ready = 0;
    chk({nm, " in_ready after"}, in_ready, 1);
  endtask

  initial begin
    int lat, seen;
    tv[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tv[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tv[3]  = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
    tv[4]  = '{8'h00, 8'hA5, 1'b0, 16'h0000};
    tv[5]  = '{8'h00, 8'hA5, 1'b1, 16'h0000};
    tv[6]  = '{8'h5A, 8'h01, 1'b0, 16'h005A};
    tv[7]  = '{8'h5A, 8'h01, 1'b1, 16'h005A};
    tv[8]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    tv[9]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tv[10] = '{8'h7F, 8'h81, 1'b0, 16'h3FFF};
    tv[11] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    step();
    step();
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset P", P, 0);
    rst = 0;
    step();
    foreach (tv[i]) xact8(tv[i].a, tv[i].b, tv[i].s, tv[i].p, $sformatf("vec%0d", i));

    // back-pressure with a pending request
    A = 8'h12; B = 8'h34; sm = 0; in_valid = 1;
    step();
    in_valid = 0;
    wait_ov(lat);
    chk("bp latency", lat, 8);
    A = 8'hFF; B = 8'hFF; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      chk("bp P", P, 16'h03A8);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    in_valid = 0;
    chk("bp release in_ready", in_ready, 1);
    chk("bp release P", P, 16'h03A8);
    step();
    chk("bp no accept", busy, 0);

    // reset during RUN
    A = 8'h7F; B = 8'h7F; in_valid = 1;
    step();
    in_valid = 0;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst P", P, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("midrst no result", seen, 0);
    xact8(8'h03, 8'h05, 1'b0, 16'h000F, "post-rst");

    // reset wins over a simultaneous request
    A = 8'h11; B = 8'h11; in_valid = 1; rst = 1;
    step();
    rst = 0; in_valid = 0;
    chk("rst+in_valid busy", busy, 0);
    step();
    chk("rst+in_valid idle", busy, 0);

    // exhaustive 4-bit, all three BPC instances in lockstep
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          int x, y;
          logic [7:0] e;
          int got [3];
          a4 = 4'(a); b4 = 4'(b); sm4 = s[0]; iv4 = 1;
          x = s ? int'($signed(a4)) : a;
          y = s ? int'($signed(b4)) : b;
          e = 8'(x * y);
          got = '{0, 0, 0};
          step();
          iv4 = 0;
          for (int c = 1; c <= 6; c++) begin
            step();
            for (int k = 0; k < 3; k++)
              if (ov4[k] && got[k] == 0) begin
                got[k] = c;
                chk($sformatf("w4 bpc%0d s%0d %0d*%0d P", 1 << k, s, a, b), p4[k], e);
              end
          end
          for (int k = 0; k < 3; k++)
            chk($sformatf("w4 bpc%0d s%0d %0d*%0d latency", 1 << k, s, a, b), got[k], 4 >> k);
        end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
